// File: rtl/display_arbiter.sv
// Display owner arbiter: shares the 128b matrix frame and 32b numbers word between two requesters.
// Define ARB_BLANK_EN to insert a blank frame of BLANK_CYC cycles on every owner handoff.
`timescale 1ns/1ps

module display_arbiter #(
    parameter int unsigned MIN_HOLD  = 1_000_000,
    parameter int unsigned BLANK_CYC = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   upd,
    input  logic [127:0] matrix_in0,
    input  logic [127:0] matrix_in1,
    input  logic [31:0]  num_in0,
    input  logic [31:0]  num_in1,
    output logic [1:0]   grant,
    output logic [127:0] matrix_out,
    output logic [31:0]  num_out,
    output logic         busy
);

    localparam int unsigned HW = $clog2(MIN_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

`ifdef ARB_BLANK_EN
    localparam int unsigned BW = $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BLANK_END = BW'(BLANK_CYC);
`endif

    if (MIN_HOLD < 1 || BLANK_CYC < 1) begin : g_param_check
        $error("display_arbiter: MIN_HOLD and BLANK_CYC must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
`ifdef ARB_BLANK_EN
        OWN1  = 2'd2,
        BLANK = 2'd3
`else
        OWN1  = 2'd2
`endif
    } state_e;

    state_e         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [127:0]   matrix_q, matrix_d;
    logic [31:0]    num_q, num_d;
    logic           handoff;
    logic           hto;

`ifdef ARB_BLANK_EN
    logic [BW-1:0]  blank_q, blank_d;
    logic           tgt_q, tgt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            matrix_q <= '0;
            num_q    <= '0;
`ifdef ARB_BLANK_EN
            blank_q  <= '0;
            tgt_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            matrix_q <= matrix_d;
            num_q    <= num_d;
`ifdef ARB_BLANK_EN
            blank_q  <= blank_d;
            tgt_q    <= tgt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        matrix_d = matrix_q;
        num_d    = num_q;
        handoff  = 1'b0;
        hto      = 1'b0;
`ifdef ARB_BLANK_EN
        blank_d  = blank_q;
        tgt_d    = tgt_q;
`endif

        // Transition decision; data loading is keyed off the chosen next state below.
        case (state_q)
            IDLE: begin
                if (req[1]) begin
                    state_d = OWN1;
                end else if (req[0]) begin
                    state_d = OWN0;
                end
            end
            OWN0: begin
                if (!req[0]) begin
                    if (req[1]) begin
                        handoff = 1'b1;
                        hto     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (req[1] && (hold_q == HOLD_MAX)) begin
                    handoff = 1'b1;
                    hto     = 1'b1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    if (req[0]) begin
                        handoff = 1'b1;
                        hto     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef ARB_BLANK_EN
            BLANK: begin
                if (blank_q == BLANK_END) begin
                    blank_d = '0;
                    if (req[tgt_q]) begin
                        state_d = tgt_q ? OWN1 : OWN0;
                    end else if (req[!tgt_q]) begin
                        state_d = tgt_q ? OWN0 : OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (handoff) begin
`ifdef ARB_BLANK_EN
            state_d = BLANK;
            tgt_d   = hto;
            blank_d = BW'(1);
`else
            state_d = hto ? OWN1 : OWN0;
`endif
        end

        case (state_d)
            OWN0: begin
                if (state_q != OWN0) begin
                    matrix_d = matrix_in0;
                    num_d    = num_in0;
                    hold_d   = '0;
                end else begin
                    if (upd[0]) begin
                        matrix_d = matrix_in0;
                        num_d    = num_in0;
                    end
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            OWN1: begin
                if (state_q != OWN1) begin
                    matrix_d = matrix_in1;
                    num_d    = num_in1;
                    hold_d   = '0;
                end else begin
                    if (upd[1]) begin
                        matrix_d = matrix_in1;
                        num_d    = num_in1;
                    end
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
`ifdef ARB_BLANK_EN
            BLANK: begin
                matrix_d = '0;
                num_d    = '0;
            end
`endif
            default: begin
                matrix_d = matrix_q;
                num_d    = num_q;
            end
        endcase
    end

    assign grant      = {state_q == OWN1, state_q == OWN0};
    assign busy       = (state_q != IDLE);
    assign matrix_out = matrix_q;
    assign num_out    = num_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter (MIN_HOLD=8, BLANK_CYC=4); follows ARB_BLANK_EN when defined.
`timescale 1ns/1ps

module tb_display_arbiter;

    localparam int unsigned MIN_HOLD  = 8;
    localparam int unsigned BLANK_CYC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   req = '0;
    logic [1:0]   upd = '0;
    logic [127:0] matrix_in0 = '0;
    logic [127:0] matrix_in1 = '0;
    logic [31:0]  num_in0 = '0;
    logic [31:0]  num_in1 = '0;
    logic [1:0]   grant;
    logic [127:0] matrix_out;
    logic [31:0]  num_out;
    logic         busy;

    always #5 clk = ~clk;

    display_arbiter #(
        .MIN_HOLD  (MIN_HOLD),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .upd        (upd),
        .matrix_in0 (matrix_in0),
        .matrix_in1 (matrix_in1),
        .num_in0    (num_in0),
        .num_in1    (num_in1),
        .grant      (grant),
        .matrix_out (matrix_out),
        .num_out    (num_out),
        .busy       (busy)
    );

    typedef struct {
        string        tag;
        logic [1:0]   grant;
        logic [127:0] mat;
        logic [31:0]  num;
        logic         busy;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [127:0] FR_A5 = {16{8'hA5}};
    localparam logic [127:0] FR_3C = {16{8'h3C}};
    localparam logic [127:0] FR_0F = {16{8'h0F}};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] g, input logic [127:0] m,
                            input logic [31:0] n, input logic b);
        exp_t e;
        e.tag   = tag;
        e.grant = g;
        e.mat   = m;
        e.num   = n;
        e.busy  = b;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        e = sb.pop_front();
        check_eq({e.tag, ".grant"},  128'(grant),      128'(e.grant));
        check_eq({e.tag, ".matrix"}, matrix_out,       e.mat);
        check_eq({e.tag, ".num"},    128'(num_out),    128'(e.num));
        check_eq({e.tag, ".busy"},   128'(busy),       128'(e.busy));
    endtask

    task automatic cyc(input string tag, input logic [1:0] g, input logic [127:0] m,
                       input logic [31:0] n, input logic b);
        push_exp(tag, g, m, n, b);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic expect_handoff(input string tag, input logic [1:0] g, input logic [127:0] m,
                                  input logic [31:0] n);
`ifdef ARB_BLANK_EN
        for (int i = 0; i < int'(BLANK_CYC); i++) begin
            cyc($sformatf("%s_blank%0d", tag, i), 2'b00, '0, '0, 1'b1);
        end
`endif
        cyc(tag, g, m, n, 1'b1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #10;
        push_exp("reset", 2'b00, '0, '0, 1'b0);
        pop_compare();
        rst_n = 1'b1;

        cyc("idle", 2'b00, '0, '0, 1'b0);

        matrix_in0 = FR_A5;
        num_in0    = 32'h1234_5678;
        req        = 2'b01;
        cyc("own0_entry", 2'b01, FR_A5, 32'h1234_5678, 1'b1);

        upd        = 2'b10;
        num_in1    = 32'hDEAD_BEEF;
        matrix_in1 = FR_0F;
        cyc("upd_nonowner", 2'b01, FR_A5, 32'h1234_5678, 1'b1);

        upd     = 2'b01;
        num_in0 = 32'h0000_0042;
        cyc("upd_owner", 2'b01, FR_A5, 32'h0000_0042, 1'b1);

        upd        = 2'b00;
        matrix_in0 = FR_3C;
        cyc("no_upd", 2'b01, FR_A5, 32'h0000_0042, 1'b1);

        // hold is 3 here; preemption only once it reaches MIN_HOLD
        req = 2'b11;
        for (int h = 4; h <= int'(MIN_HOLD); h++) begin
            cyc($sformatf("hold%0d", h), 2'b01, FR_A5, 32'h0000_0042, 1'b1);
        end
        expect_handoff("preempt", 2'b10, FR_0F, 32'hDEAD_BEEF);

        upd     = 2'b01;
        num_in0 = 32'h0000_0055;
        cyc("own1_upd0_ignored", 2'b10, FR_0F, 32'hDEAD_BEEF, 1'b1);
        upd = 2'b00;
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("no_preempt%0d", i), 2'b10, FR_0F, 32'hDEAD_BEEF, 1'b1);
        end

        req = 2'b01;
        expect_handoff("release1", 2'b01, FR_3C, 32'h0000_0055);

        req = 2'b00;
        cyc("release0_idle", 2'b00, FR_3C, 32'h0000_0055, 1'b0);
        cyc("idle_hold", 2'b00, FR_3C, 32'h0000_0055, 1'b0);

        req = 2'b11;
        cyc("idle_both", 2'b10, FR_0F, 32'hDEAD_BEEF, 1'b1);
        req = 2'b00;
        cyc("own1_idle", 2'b00, FR_0F, 32'hDEAD_BEEF, 1'b0);

`ifdef ARB_BLANK_EN
        req = 2'b01;
        cyc("b_own0", 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        req = 2'b10;
        cyc("b_enter", 2'b00, '0, '0, 1'b1);
        req = 2'b01;
        for (int i = 1; i < int'(BLANK_CYC); i++) begin
            cyc($sformatf("b_mid%0d", i), 2'b00, '0, '0, 1'b1);
        end
        cyc("b_redirect", 2'b01, FR_3C, 32'h0000_0055, 1'b1);

        req = 2'b10;
        cyc("b_enter2", 2'b00, '0, '0, 1'b1);
        req = 2'b00;
        for (int i = 1; i < int'(BLANK_CYC); i++) begin
            cyc($sformatf("b2_mid%0d", i), 2'b00, '0, '0, 1'b1);
        end
        cyc("b_idle", 2'b00, '0, '0, 1'b0);
`else
        req = 2'b01;
        cyc("d_own0", 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        req = 2'b10;
        cyc("d_direct", 2'b10, FR_0F, 32'hDEAD_BEEF, 1'b1);
        req = 2'b01;
        cyc("d_back", 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        req = 2'b00;
        cyc("d_idle", 2'b00, FR_3C, 32'h0000_0055, 1'b0);
`endif

        req = 2'b01;
        cyc("r_own0", 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        push_exp("async_rst", 2'b00, '0, '0, 1'b0);
        pop_compare();
        #2 rst_n = 1'b1;

        cyc("post_rst", 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        req = 2'b11;
        for (int h = 1; h <= int'(MIN_HOLD); h++) begin
            cyc($sformatf("rst_hold%0d", h), 2'b01, FR_3C, 32'h0000_0055, 1'b1);
        end
        expect_handoff("rst_preempt", 2'b10, FR_0F, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
